hazard_stall_unit: RTL
======================

# hazard_stall_unit

Pipeline hazard and stall controller for the five-stage RV32I core, placed beside the forwarding unit and driving the enables and flushes of PC, IF/ID and ID/EX.
- Detects hazards the forwarding unit cannot resolve:
  - load-use dependencies;
  - taken control transfers;
  - data-memory accesses that are not yet acknowledged.
- Converts them into stall, bubble and flush controls.
- Tracks long memory waits with a watchdog FSM and keeps stall/flush performance counters.

## Interface
Parameters:
- MEM_TIMEOUT, 16: cycles in MEM_WAIT before mem_timeout_err sets (≥2).
- CNT_W, 32: width of performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ID_rs1Addr  in  5  rs1 of the instruction in ID.
- ID_rs2Addr  in  5  rs2 of the instruction in ID.
- ID_opCode  in  7  opcode in ID.
- EX_rdAddr  in  5  rd of the instruction in EX.
- EX_opCode  in  7  opcode in EX.
- EX_reg_W_En  in  1  EX instruction writes the register file.
- EX_branchTaken  in  1  EX resolved a taken branch, JAL or JALR.
- MEM_memAccess  in  1  MEM stage performs a load or store this cycle.
- dmem_ready  in  1  data memory completes the MEM access this cycle.
- pcWrite_En  out  1  PC update enable.
- IFID_write_En  out  1  IF/ID register load enable.
- IFID_flush  out  1  IF/ID register cleared to NOP.
- IDEX_write_En  out  1  ID/EX register load enable.
- IDEX_flush  out  1  ID/EX register cleared to bubble.
- EXMEM_write_En  out  1  EX/MEM register load enable.
- MEMWB_bubble  out  1  MEM/WB loads a bubble (reg_W_En=0).
- mem_timeout_err  out  1  sticky watchdog flag.
- stall_cycles  out  CNT_W  count of cycles with pcWrite_En=0.
- flush_count  out  CNT_W  count of cycles with IFID_flush=1.

## Operation
Terms:
- rs1Used: ID_opCode not in {0110111 LUI, 0010111 AUIPC, 1101111 JAL}.
- rs2Used: ID_opCode in {0110011, 1100011}. Store rs2 is excluded because the WB→MEM forwarding path covers it.
- loadUse: EX_opCode==0000011 && EX_reg_W_En && EX_rdAddr!=0 && ((rs1Used && ID_rs1Addr==EX_rdAddr) || (rs2Used && ID_rs2Addr==EX_rdAddr)).
- memBusy: MEM_memAccess && !dmem_ready.

Priority, highest first:
1. **memBusy (freeze)**
   - pcWrite_En, IFID_write_En, IDEX_write_En and EXMEM_write_En all 0.
   - MEMWB_bubble=1.
   - No flushes, even if EX_branchTaken=1; the branch is re-evaluated after the freeze.
2. **EX_branchTaken**
   - IFID_flush=1 and IDEX_flush=1.
   - All enables 1.
   - Overrides loadUse, because the dependent instruction is squashed.
3. **loadUse**
   - pcWrite_En=0 and IFID_write_En=0.
   - IDEX_flush=1 (one bubble).
   - IDEX_write_En and EXMEM_write_En stay 1.
4. **Otherwise:** all enables 1, flushes 0, MEMWB_bubble=0.

A load-use stall lasts exactly one cycle: the bubble then sits in EX, so loadUse deasserts.

FSM (registered state, outputs above remain combinational on current inputs):
- RUN: memBusy → MEM_WAIT with wait_cnt←1; otherwise stay.
- MEM_WAIT:
  - dmem_ready or !MEM_memAccess → RUN, wait_cnt←0.
  - Otherwise wait_cnt+1.
  - Reaching MEM_TIMEOUT → MEM_TIMEOUT state and mem_timeout_err←1.
- MEM_TIMEOUT:
  - Freeze continues while memBusy.
  - Exit to RUN when memBusy deasserts.
  - mem_timeout_err stays 1 until reset.

wait_cnt width is clog2(MEM_TIMEOUT+1) and it saturates at MEM_TIMEOUT.

Counters:
- Update on every rising edge when rst_n=1.
- Wrap modulo 2^CNT_W.

## Timing
- Stall, flush and enable outputs: zero-latency combinational from current-cycle inputs. The registers act on the next rising edge.
- State, wait_cnt, mem_timeout_err and counters are registered.
- Reset asynchronous:
  - Asserting rst_n=0 forces state=RUN, wait_cnt=0, mem_timeout_err=0, stall_cycles=0, flush_count=0 immediately.
  - While rst_n=0, combinational outputs are forced: pcWrite_En=0, IFID_write_En=0, IDEX_write_En=0, EXMEM_write_En=0, IFID_flush=1, IDEX_flush=1, MEMWB_bubble=1.
  - Reset in MEM_WAIT or MEM_TIMEOUT drops to RUN with no residual stall.
- First edge after rst_n rises: normal operation from RUN.
- An access granted in its first cycle (dmem_ready=1) causes no freeze and no FSM transition.
- memBusy and loadUse together: the freeze wins. loadUse is re-evaluated when the freeze releases, and the inputs are unchanged because the pipeline held.

## Test plan
- Load-use on rs1: EX `lw x5`, ID `add x6,x5,x1` → one cycle pcWrite_En=0, IFID_write_En=0, IDEX_flush=1, then normal; stall_cycles 0→1.
- Load-use exemptions:
  - EX `lw x5`, ID `sw x5,0(x2)` (rs2 match) → no stall.
  - EX `lw x0` → no stall.
  - EX `lw x5`, ID `lui x5` → no stall.
- Branch flush over load-use: EX_branchTaken=1 with loadUse true → IFID_flush=IDEX_flush=1, pcWrite_En=1; flush_count increments by 1.
- Memory wait: MEM_memAccess=1, dmem_ready=0 for 3 cycles, then 1 → freeze and MEMWB_bubble=1 for 3 cycles; state RUN→MEM_WAIT→RUN; stall_cycles +3; a concurrent EX_branchTaken produces no flush during the freeze.
- Watchdog: MEM_TIMEOUT=4, dmem_ready held 0 for 6 cycles → mem_timeout_err=1 after the 4th wait cycle; freeze persists; flag stays 1 after ready until rst_n pulse.
- Async reset mid-wait: rst_n=0 between edges in MEM_WAIT → counters/flag 0 and flush outputs 1 immediately without a clock; RUN after release.

Source files
------------

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_unit
//  Description : Hazard and stall controller for the five-stage RV32I core.
//                Turns load-use dependencies, taken control transfers and
//                unacknowledged data-memory accesses into PC/IF/ID/EX/MEM
//                enables, flushes and a MEM/WB bubble. Also runs a watchdog
//                over long memory waits and keeps stall/flush counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ID_rs1Addr,
    input  logic [4:0]       ID_rs2Addr,
    input  logic [6:0]       ID_opCode,
    input  logic [4:0]       EX_rdAddr,
    input  logic [6:0]       EX_opCode,
    input  logic             EX_reg_W_En,
    input  logic             EX_branchTaken,
    input  logic             MEM_memAccess,
    input  logic             dmem_ready,
    output logic             pcWrite_En,
    output logic             IFID_write_En,
    output logic             IFID_flush,
    output logic             IDEX_write_En,
    output logic             IDEX_flush,
    output logic             EXMEM_write_En,
    output logic             MEMWB_bubble,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] c_WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    localparam logic [1:0] c_ST_RUN      = 2'd0;
    localparam logic [1:0] c_ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] c_ST_TIMEOUT  = 2'd2;

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    logic              w_rs1_used;
    logic              w_rs2_used;
    logic              w_load_use;
    logic              w_mem_busy;

    logic [1:0]        state_q,           state_d;
    logic [WAIT_W-1:0] wait_cnt_q,        wait_cnt_d;
    logic              mem_timeout_err_q, mem_timeout_err_d;
    logic [CNT_W-1:0]  stall_cycles_q,    stall_cycles_d;
    logic [CNT_W-1:0]  flush_count_q,     flush_count_d;

    // Hazard detection; store rs2 is not a load-use source since WB->MEM forwarding covers it
    always_comb begin
        w_rs1_used = (ID_opCode != c_OP_LUI) && (ID_opCode != c_OP_AUIPC) &&
                     (ID_opCode != c_OP_JAL);
        w_rs2_used = (ID_opCode == c_OP_REG) || (ID_opCode == c_OP_BRANCH);
        w_load_use = (EX_opCode == c_OP_LOAD) && EX_reg_W_En && (EX_rdAddr != 5'd0) &&
                     ((w_rs1_used && (ID_rs1Addr == EX_rdAddr)) ||
                      (w_rs2_used && (ID_rs2Addr == EX_rdAddr)));
        w_mem_busy = MEM_memAccess && !dmem_ready;
    end

    // Pipeline controls by priority: reset, memory freeze, taken branch, load-use
    always_comb begin
        pcWrite_En     = 1'b1;
        IFID_write_En  = 1'b1;
        IFID_flush     = 1'b0;
        IDEX_write_En  = 1'b1;
        IDEX_flush     = 1'b0;
        EXMEM_write_En = 1'b1;
        MEMWB_bubble   = 1'b0;
        if (!rst_n) begin
            pcWrite_En     = 1'b0;
            IFID_write_En  = 1'b0;
            IFID_flush     = 1'b1;
            IDEX_write_En  = 1'b0;
            IDEX_flush     = 1'b1;
            EXMEM_write_En = 1'b0;
            MEMWB_bubble   = 1'b1;
        end else if (w_mem_busy) begin
            // Whole pipeline holds; a pending branch is re-evaluated afterwards
            pcWrite_En     = 1'b0;
            IFID_write_En  = 1'b0;
            IDEX_write_En  = 1'b0;
            EXMEM_write_En = 1'b0;
            MEMWB_bubble   = 1'b1;
        end else if (EX_branchTaken) begin
            IFID_flush     = 1'b1;
            IDEX_flush     = 1'b1;
        end else if (w_load_use) begin
            pcWrite_En     = 1'b0;
            IFID_write_En  = 1'b0;
            IDEX_flush     = 1'b1;
        end
    end

    // Watchdog FSM next state and performance counter increments
    always_comb begin
        state_d           = state_q;
        wait_cnt_d        = wait_cnt_q;
        mem_timeout_err_d = mem_timeout_err_q;
        stall_cycles_d    = stall_cycles_q + (pcWrite_En ? CNT_W'(0) : CNT_W'(1));
        flush_count_d     = flush_count_q  + (IFID_flush ? CNT_W'(1) : CNT_W'(0));
        case (state_q)
            c_ST_RUN: begin
                if (w_mem_busy) begin
                    state_d    = c_ST_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            c_ST_MEM_WAIT: begin
                if (!w_mem_busy) begin
                    state_d    = c_ST_RUN;
                    wait_cnt_d = '0;
                end else begin
                    if (wait_cnt_q != c_WAIT_MAX) begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                    if (wait_cnt_d == c_WAIT_MAX) begin
                        state_d           = c_ST_TIMEOUT;
                        mem_timeout_err_d = 1'b1;
                    end
                end
            end
            c_ST_TIMEOUT: begin
                if (!w_mem_busy) begin
                    state_d    = c_ST_RUN;
                    wait_cnt_d = '0;
                end
            end
            default: begin
                state_d    = c_ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Registered FSM state, sticky error flag and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= c_ST_RUN;
            wait_cnt_q        <= '0;
            mem_timeout_err_q <= 1'b0;
            stall_cycles_q    <= '0;
            flush_count_q     <= '0;
        end else begin
            state_q           <= state_d;
            wait_cnt_q        <= wait_cnt_d;
            mem_timeout_err_q <= mem_timeout_err_d;
            stall_cycles_q    <= stall_cycles_d;
            flush_count_q     <= flush_count_d;
        end
    end

    assign mem_timeout_err = mem_timeout_err_q;
    assign stall_cycles    = stall_cycles_q;
    assign flush_count     = flush_count_q;

endmodule
`default_nettype wire
